// File: rtl/avr_tx_arbiter.sv
// avr_tx_arbiter: round-robin byte arbiter feeding the AVR serial transmitter.
// Define AVR_TX_ARB_LOCK_EN to build the per-requester burst lock.
module avr_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BURST_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 link_ready,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   lock,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           tx_data,
    output logic                 tx_new_data,
    input  logic                 tx_busy,
    output logic                 active
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [2:0] {DISABLED, IDLE, SEND, GUARD, WAIT} state_t;
    state_t state, state_n;
    logic [IW-1:0] last_grant, rr_win, sel;
    logic rr_hit, lock_hit, go;
    logic [NUM_REQ-1:0] ack_n;
    logic [7:0] data_n;
    // Walk from farthest to nearest so the requester right after last_grant wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_win = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % NUM_REQ]) begin
                rr_hit = 1'b1;
                rr_win = IW'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end
`ifdef AVR_TX_ARB_LOCK_EN
    logic [7:0] burst;
    assign lock_hit = lock[last_grant] && req[last_grant] && burst < 8'(BURST_MAX - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            burst <= '0;
        else if (!link_ready)
            burst <= '0;
        else if (state == WAIT && !tx_busy)
            burst <= lock_hit ? burst + 8'd1 : '0;
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign lock_hit = 1'b0;
`endif
    always_comb begin
        state_n = state;
        go = 1'b0;
        sel = rr_win;
        if (!link_ready)
            state_n = DISABLED;
        else
            case (state)
                DISABLED: state_n = IDLE;
                IDLE:     go = !tx_busy && rr_hit;
                SEND:     state_n = GUARD;
                GUARD:    state_n = WAIT;
                WAIT: if (!tx_busy) begin
                    go = lock_hit || rr_hit;
                    sel = lock_hit ? last_grant : rr_win;
                    state_n = IDLE;
                end
                default:  state_n = DISABLED;
            endcase
        if (go)
            state_n = SEND;
        ack_n = go ? NUM_REQ'(1) << sel : '0;
        data_n = go ? req_data[{sel, 3'b000} +: 8] : tx_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DISABLED;
            last_grant <= IW'(NUM_REQ - 1);
            ack <= '0;
            tx_data <= '0;
            tx_new_data <= 1'b0;
            active <= 1'b0;
        end else begin
            state <= state_n;
            if (go)
                last_grant <= sel;
            ack <= ack_n;
            tx_data <= data_n;
            tx_new_data <= go;
            active <= state_n != DISABLED;
        end
    end
endmodule

// File: tb/tb_avr_tx_arbiter.sv
// tb_avr_tx_arbiter: randomized and directed checks of avr_tx_arbiter against a grant-level model.
module tb_avr_tx_arbiter;
    localparam int N = 4;
    localparam int BM = 4;
`ifdef AVR_TX_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, link_ready = 1'b0, tx_busy = 1'b0;
    logic [N-1:0] req = '0, lock = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] ack;
    logic [7:0] tx_data;
    logic tx_new_data, active;
    int errors = 0, checks = 0;
    int gq[$];
    avr_tx_arbiter #(.NUM_REQ(N), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst), .link_ready(link_ready), .req(req), .req_data(req_data),
        .lock(lock), .ack(ack), .tx_data(tx_data), .tx_new_data(tx_new_data),
        .tx_busy(tx_busy), .active(active)
    );
    always #5 clk = ~clk;
    // Grant-level model: a strobe may follow the previous one no sooner than 3 edges,
    // and the selection rules are applied to the inputs seen at that edge.
    int m_last = N - 1, m_burst = 0, m_since = 3, m_w;
    bit m_en = 0, m_chain = 0;
    bit e_new = 0, e_active = 0;
    logic [N-1:0] e_ack = '0;
    logic [7:0] e_data = '0;
    always @(posedge clk) begin
        if (rst) begin
            m_last = N - 1; m_burst = 0; m_since = 3; m_en = 0; m_chain = 0;
            e_new = 0; e_ack = '0; e_data = '0; e_active = 0;
        end else if (!link_ready) begin
            m_en = 0; m_chain = 0; m_burst = 0; m_since = 3;
            e_new = 0; e_ack = '0; e_active = 0;
        end else begin
            m_w = -1;
            if (m_since < 3) m_since++;
            if (m_en && !tx_busy && m_since >= 3) begin
                if (LOCK_ON && m_chain && lock[m_last] && req[m_last] && m_burst < BM - 1) begin
                    m_w = m_last;
                    m_burst++;
                end else begin
                    m_burst = 0;
                    for (int k = 1; k <= N; k++)
                        if (m_w < 0 && req[(m_last + k) % N]) m_w = (m_last + k) % N;
                    if (m_w < 0) m_chain = 0;
                end
            end
            e_new = m_w >= 0;
            e_ack = '0;
            if (m_w >= 0) begin
                e_ack[m_w] = 1'b1;
                e_data = req_data[8*m_w +: 8];
                m_last = m_w;
                m_since = 0;
                m_chain = 1;
            end
            m_en = 1;
            e_active = 1;
        end
    end
    function automatic int idx(input logic [N-1:0] a);
        idx = -1;
        for (int i = 0; i < N; i++) if (a[i]) idx = i;
    endfunction
    task automatic do_reset();
        @(negedge clk);
        rst = 1; link_ready = 0; req = '0; lock = '0; tx_busy = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        gq.delete();
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_new_data, ack, active, tx_data} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got new=%b ack=%b act=%b data=%h, want all zero", tx_new_data, ack, active, tx_data);
        end
        rst = 0;
    endtask
    task automatic test_first_byte();
        int n = 0;
        link_ready = 1; req = 4'b0001; req_data = 32'h0000_0041;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if ({tx_new_data, ack, active, tx_data} !== {e_new, e_ack, e_active, e_data}) begin
                errors++;
                $display("FAIL first_cycle c=%0d: got %b %b %b %h, want %b %b %b %h", c, tx_new_data, ack, active, tx_data, e_new, e_ack, e_active, e_data);
            end
            if (tx_new_data) begin
                n++;
                checks++;
                if (c != 2 || tx_data !== 8'h41 || ack !== 4'b0001) begin
                    errors++;
                    $display("FAIL first_strobe: got cycle=%0d data=%h ack=%b, want cycle=2 data=41 ack=0001", c, tx_data, ack);
                end
                req = '0;
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL first_count: got %0d strobes, want 1", n);
        end
    endtask
    task automatic test_round_robin();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        int bc = 0, last_s = -100;
        logic [N-1:0] pend = '0;
        do_reset();
        link_ready = 1; req = 4'b1111; req_data = $urandom;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if ({tx_new_data, ack, active, tx_data} !== {e_new, e_ack, e_active, e_data}) begin
                errors++;
                $display("FAIL rr_cycle c=%0d: got %b %b %b %h, want %b %b %b %h", c, tx_new_data, ack, active, tx_data, e_new, e_ack, e_active, e_data);
            end
            req |= pend;
            pend = '0;
            if (tx_new_data) begin
                checks++;
                if (c - last_s < 3) begin
                    errors++;
                    $display("FAIL rr_spacing: got %0d cycles, want >= 3", c - last_s);
                end
                last_s = c;
                gq.push_back(idx(ack));
                req &= ~ack;
                pend = ack;
                bc = 5;
            end
            tx_busy = bc > 0;
            if (bc > 0) bc--;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (gq.size() <= i || gq[i] != exp_g[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d, want %0d", i, gq.size() > i ? gq[i] : -1, exp_g[i]);
            end
        end
    endtask
    task automatic test_link_drop();
        int bc = 0, sf = 0;
        do_reset();
        link_ready = 1; req = 4'b0110; req_data = $urandom;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            checks++;
            if ({tx_new_data, ack, active, tx_data} !== {e_new, e_ack, e_active, e_data}) begin
                errors++;
                $display("FAIL drop_cycle c=%0d: got %b %b %b %h, want %b %b %b %h", c, tx_new_data, ack, active, tx_data, e_new, e_ack, e_active, e_data);
            end
            if (tx_new_data) begin
                gq.push_back(idx(ack));
                bc = 5;
            end
            tx_busy = bc > 0;
            if (bc > 0) bc--;
            if (gq.size() == 1) sf++;
            if (sf == 3) link_ready = 0;
            if (sf == 4) begin
                checks++;
                if (active !== 1'b0 || tx_new_data !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_disable: got active=%b new=%b, want 0 0", active, tx_new_data);
                end
            end
            if (sf == 5) link_ready = 1;
        end
        checks++;
        if (gq.size() < 2 || gq[0] != 1 || gq[1] != 2) begin
            errors++;
            $display("FAIL drop_regrant: got %0d grants first=%0d second=%0d, want 1 then 2", gq.size(), gq.size() > 0 ? gq[0] : -1, gq.size() > 1 ? gq[1] : -1);
        end
    endtask
    task automatic test_lock();
`ifdef AVR_TX_ARB_LOCK_EN
        int exp_g[6] = '{0, 2, 2, 2, 2, 0};
`else
        int exp_g[6] = '{0, 2, 0, 2, 0, 2};
`endif
        int bc = 0;
        do_reset();
        link_ready = 1; req = 4'b0101; lock = 4'b0100; req_data = $urandom;
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            checks++;
            if ({tx_new_data, ack, active, tx_data} !== {e_new, e_ack, e_active, e_data}) begin
                errors++;
                $display("FAIL lock_cycle c=%0d: got %b %b %b %h, want %b %b %b %h", c, tx_new_data, ack, active, tx_data, e_new, e_ack, e_active, e_data);
            end
            if (tx_new_data) begin
                gq.push_back(idx(ack));
                bc = 5;
            end
            tx_busy = bc > 0;
            if (bc > 0) bc--;
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (gq.size() <= i || gq[i] != exp_g[i]) begin
                errors++;
                $display("FAIL lock_order[%0d]: got %0d, want %0d", i, gq.size() > i ? gq[i] : -1, exp_g[i]);
            end
        end
    endtask
    task automatic test_random();
        int last_s = -100;
        do_reset();
        link_ready = 1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if ({tx_new_data, ack, active, tx_data} !== {e_new, e_ack, e_active, e_data}) begin
                errors++;
                $display("FAIL rand_cycle c=%0d: got %b %b %b %h, want %b %b %b %h", c, tx_new_data, ack, active, tx_data, e_new, e_ack, e_active, e_data);
            end
            if (tx_new_data) begin
                checks++;
                if (c - last_s < 3 || !$onehot(ack)) begin
                    errors++;
                    $display("FAIL rand_spacing: got gap=%0d ack=%b, want gap>=3 one-hot", c - last_s, ack);
                end
                last_s = c;
            end
            req = N'($urandom);
            lock = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
            req_data = $urandom;
            tx_busy = $urandom_range(0, 9) < 5;
            link_ready = $urandom_range(0, 39) != 0;
        end
    endtask
    task automatic test_async_reset();
        bit seen = 0;
        do_reset();
        link_ready = 1; req = 4'b0011; req_data = 32'h5A5A_5A5A;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = tx_new_data;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL async_setup: got no strobe within 10 cycles, want one");
        end
        #1 rst = 1;
        #1;
        checks++;
        if ({tx_new_data, ack, active, tx_data} !== 14'h0) begin
            errors++;
            $display("FAIL async_reset: got new=%b ack=%b act=%b data=%h, want all zero", tx_new_data, ack, active, tx_data);
        end
        @(negedge clk);
        rst = 0;
    endtask
    initial begin
        test_reset();
        test_first_byte();
        test_round_robin();
        test_link_drop();
        test_lock();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
